// File: rtl/uart_pkg.sv
// uart_pkg: shared transmit-path state encoding and timing constants
package uart_pkg;
  typedef enum logic [2:0] {IDLE, SEND0, WAIT0, SEND1, WAIT1, DONE} txState_e;
  localparam int BAUD_TICKS_PER_BYTE = 52080;
  localparam int DEFAULT_TIMEOUT_CYC = 120000;
endpackage

// File: rtl/uart_tx_arbiter_rr_picker.sv
// rr_picker: first set req after rrPtr, wrapping modulo N_REQ; ports req/rrPtr in, valid/idx out
module rr_picker #(
  parameter int N_REQ = 4
) (
  input  logic [N_REQ-1:0] req,
  input  logic [2:0]       rrPtr,
  output logic             valid,
  output logic [2:0]       idx
);
  localparam int IW = $clog2(N_REQ);
  function automatic logic [IW-1:0] wrap(input int v);
    return IW'(v % N_REQ);
  endfunction
  always_comb begin
    valid = |req;
    idx = '0;
    for (int k = N_REQ; k >= 1; k--)
      if (req[wrap(int'(rrPtr) + k)]) idx = 3'(wrap(int'(rrPtr) + k));
  end
endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin 2-byte frame arbiter for one UART_tx; req/req_cmd/req_data/ack/err to sources, TxEn/TxData/TxDone to UART_tx, busy/grant_id status
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int N_REQ       = 4,
  parameter int TIMEOUT_CYC = DEFAULT_TIMEOUT_CYC
) (
  input  logic               Clk,
  input  logic               Rst_n,
  input  logic [N_REQ-1:0]   req,
  input  logic [8*N_REQ-1:0] req_cmd,
  input  logic [8*N_REQ-1:0] req_data,
  output logic [N_REQ-1:0]   ack,
  output logic               err,
  input  logic               TxDone,
  output logic               TxEn,
  output logic [7:0]         TxData,
  output logic               busy,
  output logic [2:0]         grant_id
);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYC - 1);
  localparam logic [TW-1:0] T_MAX = TW'(TIMEOUT_CYC);
  txState_e state, stateNxt;
  logic [2:0] rrPtr, rrPtrNxt, pickIdx, grantNxt;
  logic pickValid, txEnNxt, errNxt, busyNxt, expired;
  logic [7:0] cmdLat, cmdNxt, dataLat, dataNxt, txDataNxt;
  logic [N_REQ-1:0] ackNxt;
  logic [TW-1:0] timer, timerNxt;
  rr_picker #(.N_REQ(N_REQ)) picker (
    .req(req),
    .rrPtr(rrPtr),
    .valid(pickValid),
    .idx(pickIdx)
  );
  always_comb begin
    stateNxt = state;
    txEnNxt = 1'b0;
    txDataNxt = TxData;
    errNxt = 1'b0;
    busyNxt = busy;
    grantNxt = grant_id;
    rrPtrNxt = rrPtr;
    cmdNxt = cmdLat;
    dataNxt = dataLat;
    timerNxt = timer == T_MAX ? timer : timer + 1'b1;
    expired = timer >= T_LAST;
    case (state)
      IDLE: if (pickValid) begin
        stateNxt = SEND0;
        busyNxt = 1'b1;
        grantNxt = pickIdx;
        rrPtrNxt = pickIdx;
        cmdNxt = 8'(req_cmd >> {pickIdx, 3'b000});
        dataNxt = 8'(req_data >> {pickIdx, 3'b000});
      end
      SEND0, SEND1: begin
        stateNxt = state == SEND0 ? WAIT0 : WAIT1;
        txEnNxt = 1'b1;
        txDataNxt = state == SEND0 ? cmdLat : dataLat;
        timerNxt = '0;
      end
      WAIT0, WAIT1: begin
        stateNxt = TxDone ? (state == WAIT0 ? SEND1 : DONE) : expired ? DONE : state;
        errNxt = !TxDone && expired;
      end
      default: stateNxt = IDLE;
    endcase
    ackNxt = stateNxt == DONE ? N_REQ'(1) << grant_id : '0;
    busyNxt = stateNxt == DONE ? 1'b0 : busyNxt;
  end
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      state <= IDLE;
      TxEn <= 1'b0;
      TxData <= '0;
      ack <= '0;
      err <= 1'b0;
      busy <= 1'b0;
      grant_id <= '0;
      rrPtr <= 3'(N_REQ - 1);
      timer <= '0;
      cmdLat <= '0;
      dataLat <= '0;
    end else begin
      state <= stateNxt;
      TxEn <= txEnNxt;
      TxData <= txDataNxt;
      ack <= ackNxt;
      err <= errNxt;
      busy <= busyNxt;
      grant_id <= grantNxt;
      rrPtr <= rrPtrNxt;
      timer <= timerNxt;
      cmdLat <= cmdNxt;
      dataLat <= dataNxt;
    end
  end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed vector table and corner sequences for uart_tx_arbiter
module tb_uart_tx_arbiter;
  localparam int N = 4;
  localparam int TMO = 50;
  localparam int DLY = 20;
  logic Clk = 1'b0;
  logic Rst_n = 1'b0;
  logic [N-1:0] req = '0;
  logic [8*N-1:0] req_cmd, req_data;
  logic [N-1:0] ack;
  logic err, TxDone, TxEn, busy;
  logic [7:0] TxData;
  logic [2:0] grant_id;
  logic mdlDone = 1'b0;
  logic spur = 1'b0;
  logic withhold = 1'b0;
  int cnt = 0;
  int stabBad = 0;
  int total = 0;
  int bad = 0;
  logic [7:0] curByte = '0;
  logic [7:0] txLog[$];
  longint txT[$];
  longint doneT[$];
  longint t0;
  int ord[6] = '{0, 1, 3, 0, 1, 3};
  typedef struct {
    logic [N-1:0] rq;
    bit hold;
    int src;
    logic [7:0] b0;
    logic [7:0] b1;
    bit abt;
  } vec_t;
  vec_t vt[8];
  uart_tx_arbiter #(.N_REQ(N), .TIMEOUT_CYC(TMO)) dut (
    .Clk(Clk),
    .Rst_n(Rst_n),
    .req(req),
    .req_cmd(req_cmd),
    .req_data(req_data),
    .ack(ack),
    .err(err),
    .TxDone(TxDone),
    .TxEn(TxEn),
    .TxData(TxData),
    .busy(busy),
    .grant_id(grant_id)
  );
  always #5 Clk = ~Clk;
  assign TxDone = mdlDone | spur;
  always @(negedge Clk) begin
    mdlDone = 1'b0;
    if (!Rst_n) cnt = 0;
    else if (TxEn) begin
      txLog.push_back(TxData);
      txT.push_back(longint'($time));
      curByte = TxData;
      if (!withhold) cnt = DLY;
    end else if (cnt > 0) begin
      if (TxData !== curByte) stabBad++;
      cnt--;
      if (cnt == 0) begin
        mdlDone = 1'b1;
        doneT.push_back(longint'($time));
      end
    end
  end
  task automatic step();
    @(negedge Clk);
    #1;
  endtask
  task automatic check(input string n, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", n, act, exp);
    end
  endtask
  task automatic clearLog();
    txLog.delete();
    txT.delete();
    doneT.delete();
  endtask
  task automatic waitAck(output logic [N-1:0] a, output logic e, output longint t);
    a = '0;
    e = 1'b0;
    t = 0;
    for (int i = 0; i < 3000; i++) begin
      step();
      if (|ack) begin
        a = ack;
        e = err;
        t = longint'($time) - 1;
        return;
      end
    end
    total++;
    bad++;
    $display("FAIL ack_wait: no ack within 3000 cycles");
  endtask
  task automatic waitTx(input int n);
    for (int i = 0; i < 3000; i++) begin
      if (txLog.size() >= n) return;
      step();
    end
    total++;
    bad++;
    $display("FAIL tx_wait: got %0d TxEn want %0d", txLog.size(), n);
  endtask
  task automatic frame(input string tag, input int src, input logic [7:0] b0, input logic [7:0] b1, input bit abt);
    logic [N-1:0] a;
    logic e;
    longint t;
    waitAck(a, e, t);
    check({tag, ".ack"}, 32'(a), 32'(1 << src));
    check({tag, ".err"}, 32'(e), 32'(abt));
    check({tag, ".gid"}, 32'(grant_id), 32'(src));
    check({tag, ".busy"}, 32'(busy), 32'(0));
    check({tag, ".ntx"}, 32'(txLog.size()), abt ? 32'(1) : 32'(2));
    if (txLog.size() > 0) check({tag, ".b0"}, 32'(txLog[0]), 32'(b0));
    if (abt && txT.size() > 0) check({tag, ".tmo"}, 32'(t - txT[0]), 32'(TMO * 10));
    if (!abt && txLog.size() > 1) begin
      check({tag, ".b1"}, 32'(txLog[1]), 32'(b1));
      check({tag, ".gap"}, 32'(txT[1] - txT[0]), 32'(DLY * 10 + 20));
      if (doneT.size() > 1) check({tag, ".acklat"}, 32'(t - doneT[doneT.size() - 1]), 32'(10));
    end
    clearLog();
  endtask
  initial begin
    for (int i = 0; i < N; i++) begin
      req_cmd[8*i +: 8] = 8'(8'hC0 + i);
      req_data[8*i +: 8] = 8'(8'hD0 + i);
    end
    for (int i = 0; i < 6; i++)
      vt[i] = '{4'b1011, 1'b0, ord[i], 8'(8'hC0 + ord[i]), 8'(8'hD0 + ord[i]), 1'b0};
    vt[6] = '{4'b0101, 1'b1, 0, 8'hC0, 8'hD0, 1'b1};
    vt[7] = '{4'b0101, 1'b0, 2, 8'hC2, 8'hD2, 1'b0};
    repeat (3) step();
    check("rst.TxEn", 32'(TxEn), 32'(0));
    check("rst.TxData", 32'(TxData), 32'(0));
    check("rst.ack", 32'(ack), 32'(0));
    check("rst.err", 32'(err), 32'(0));
    check("rst.busy", 32'(busy), 32'(0));
    check("rst.gid", 32'(grant_id), 32'(0));
    Rst_n = 1'b1;
    step();
    req_cmd[7:0] = 8'hA1;
    req_data[7:0] = 8'h1B;
    clearLog();
    t0 = longint'($time) - 1;
    req = 4'b0001;
    waitTx(1);
    if (txT.size() > 0) check("t1.txlat", 32'(txT[0] - t0), 32'(20));
    frame("t1", 0, 8'hA1, 8'h1B, 1'b0);
    req = '0;
    req_cmd[7:0] = 8'hC0;
    req_data[7:0] = 8'hD0;
    Rst_n = 1'b0;
    repeat (2) step();
    Rst_n = 1'b1;
    step();
    clearLog();
    for (int i = 0; i < 8; i++) begin
      req = vt[i].rq;
      withhold = vt[i].hold;
      frame($sformatf("v%0d", i), vt[i].src, vt[i].b0, vt[i].b1, vt[i].abt);
    end
    req = '0;
    withhold = 1'b0;
    step();
    req = 4'b0100;
    waitTx(1);
    repeat (2) step();
    req = '0;
    req_cmd[23:16] = 8'h55;
    req_data[23:16] = 8'h66;
    frame("t3", 2, 8'hC2, 8'hD2, 1'b0);
    req_cmd[23:16] = 8'hC2;
    req_data[23:16] = 8'hD2;
    step();
    spur = 1'b1;
    step();
    spur = 1'b0;
    repeat (3) step();
    check("t6.idle_busy", 32'(busy), 32'(0));
    check("t6.idle_tx", 32'(txLog.size()), 32'(0));
    check("t6.idle_gid", 32'(grant_id), 32'(2));
    req = 4'b0100;
    step();
    check("t6.grant_busy", 32'(busy), 32'(1));
    spur = 1'b1;
    step();
    spur = 1'b0;
    frame("t6", 2, 8'hC2, 8'hD2, 1'b0);
    req = '0;
    step();
    req = 4'b0010;
    waitTx(2);
    step();
    Rst_n = 1'b0;
    req = 4'b0011;
    step();
    check("t5.TxEn", 32'(TxEn), 32'(0));
    check("t5.TxData", 32'(TxData), 32'(0));
    check("t5.busy", 32'(busy), 32'(0));
    check("t5.ack", 32'(ack), 32'(0));
    check("t5.gid", 32'(grant_id), 32'(0));
    Rst_n = 1'b1;
    clearLog();
    frame("t5a", 0, 8'hC0, 8'hD0, 1'b0);
    req = 4'b0010;
    frame("t5b", 1, 8'hC1, 8'hD1, 1'b0);
    req = '0;
    step();
    check("stable", 32'(stabBad), 32'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
